// File: rtl/ff_frame_serializer_if.sv
// Load handshake and framed serial outputs of ff_frame_serializer.
// The producer side uses the master modport and the serializer uses the slave modport.
interface ff_frame_serializer_if #(
    parameter int WIDTH = 8
);
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic             din;
    logic             sel;
    logic             busy;
    logic             done;

    modport master (
        output load_valid, load_data,
        input  load_ready, din, sel, busy, done
    );

    modport slave (
        input  load_valid, load_data,
        output load_ready, din, sel, busy, done
    );
endinterface

// File: rtl/ff_frame_serializer.sv
// Serializes accepted words into start/data/[parity]/stop frames on din/sel for the flipflop cell.
// Define FF_SERIALIZER_PARITY_EN to add an even parity bit after the last data bit.
module ff_frame_serializer #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input logic                 clk,
    input logic                 reset,
    ff_frame_serializer_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef FF_SERIALIZER_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sel_q, sel_d;
    logic               din_q, din_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef FF_SERIALIZER_PARITY_EN
    logic               parity_q, parity_d;
`endif
    logic               load_ready;
    logic               accept;

    assign load_ready = (state_q == IDLE) || (state_q == STOP);
    assign accept     = bus.load_valid && load_ready;

    always_comb begin
        // NOTE: every variable gets a default first so no path through the case infers a latch.
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
`ifdef FF_SERIALIZER_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE, STOP: begin
                state_d = IDLE;
                if (accept) begin
                    state_d = START;
                    shift_d = bus.load_data;
                    cnt_d   = '0;
`ifdef FF_SERIALIZER_PARITY_EN
                    parity_d = ^bus.load_data;
`endif
                end
            end
            START: state_d = DATA;
            DATA: begin
                shift_d = LSB_FIRST ? (shift_q >> 1) : (shift_q << 1);
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
`ifdef FF_SERIALIZER_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef FF_SERIALIZER_PARITY_EN
            PARITY: state_d = STOP;
`endif
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with the state they describe.
        sel_d  = (state_d == START) || (state_d == DATA);
        din_d  = 1'b0;
        if (state_d == DATA) begin
            din_d = LSB_FIRST ? shift_d[0] : shift_d[WIDTH-1];
        end
`ifdef FF_SERIALIZER_PARITY_EN
        if (state_d == PARITY) begin
            sel_d = 1'b1;
            din_d = parity_d;
        end
`endif
        busy_d = (state_d != IDLE);
        done_d = (state_d == STOP);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the shifter and counter are reset too, so an aborted frame leaves no stale word behind.
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            sel_q   <= 1'b0;
            din_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef FF_SERIALIZER_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            din_q   <= din_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef FF_SERIALIZER_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign bus.load_ready = load_ready;
    assign bus.sel        = sel_q;
    assign bus.din        = din_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_ff_frame_serializer.sv
// Self-checking bench: an LSB-first and an MSB-first serializer share stimulus and are
// compared cycle by cycle against queues of expected frame slots.
module tb_ff_frame_serializer;
    localparam int W = 8;
`ifdef FF_SERIALIZER_PARITY_EN
    localparam int FRAME = W + 3;
`else
    localparam int FRAME = W + 2;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ff_frame_serializer_if #(.WIDTH(W)) if_lsb ();
    ff_frame_serializer_if #(.WIDTH(W)) if_msb ();

    ff_frame_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_lsb (.clk(clk), .reset(reset), .bus(if_lsb));
    ff_frame_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (.clk(clk), .reset(reset), .bus(if_msb));

    // One expected line slot: what sel/din/done/busy must show during that cycle.
    typedef struct packed {
        logic sel;
        logic din;
        logic done;
        logic busy;
    } slot_t;

    slot_t q_lsb[$];
    slot_t q_msb[$];
    slot_t cur_lsb, cur_msb;

    int checks = 0;
    int errors = 0;
    int busy_seen = 0;
    int done_seen = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic slot_t mk(input logic s, input logic d, input logic dn, input logic b);
        slot_t r;
        r.sel = s; r.din = d; r.done = dn; r.busy = b;
        return r;
    endfunction

    // Expected frame: start 0, data bits in wire order, optional even parity, stop slot.
    task automatic push_frame(input logic [W-1:0] w, input bit lsb);
        slot_t f[$];
        f.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1));
        for (int i = 0; i < W; i++) begin
            f.push_back(mk(1'b1, lsb ? w[i] : w[W-1-i], 1'b0, 1'b1));
        end
`ifdef FF_SERIALIZER_PARITY_EN
        f.push_back(mk(1'b1, ^w, 1'b0, 1'b1));
`endif
        f.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1));
        if (lsb) q_lsb = {q_lsb, f};
        else     q_msb = {q_msb, f};
    endtask

    task automatic check_outs();
        check("lsb sel/din/done/busy", {if_lsb.sel, if_lsb.din, if_lsb.done, if_lsb.busy}, cur_lsb);
        check("msb sel/din/done/busy", {if_msb.sel, if_msb.din, if_msb.done, if_msb.busy}, cur_msb);
        check("lsb load_ready", if_lsb.load_ready, !cur_lsb.busy || cur_lsb.done);
        check("msb load_ready", if_msb.load_ready, !cur_msb.busy || cur_msb.done);
    endtask

    // Called just after a falling edge: drive, check the current slot, advance one cycle.
    task automatic cycle(input bit v, input logic [W-1:0] d);
        bit acc;
        if_lsb.load_valid = v; if_lsb.load_data = d;
        if_msb.load_valid = v; if_msb.load_data = d;
        check_outs();
        if (if_lsb.busy === 1'b1) busy_seen++;
        if (if_lsb.done === 1'b1) done_seen++;
        acc = v && (!cur_lsb.busy || cur_lsb.done);
        @(posedge clk);
        if (acc) begin
            push_frame(d, 1'b1);
            push_frame(d, 1'b0);
        end
        cur_lsb = (q_lsb.size() > 0) ? q_lsb.pop_front() : slot_t'(0);
        cur_msb = (q_msb.size() > 0) ? q_msb.pop_front() : slot_t'(0);
        @(negedge clk);
    endtask

    task automatic drain();
        repeat (FRAME + 1) cycle(1'b0, $urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        if_lsb.load_valid = 1'b0; if_lsb.load_data = '0;
        if_msb.load_valid = 1'b0; if_msb.load_data = '0;
        cur_lsb = '0;
        cur_msb = '0;
        repeat (2) @(negedge clk);
        check_outs();
        reset = 1'b1;

        // 0xA5: LSB-first wire 0,1,0,1,0,0,1,0,1 then stop, then idle.
        cycle(1'b1, 8'hA5);
        drain();

        // 0x07 exercises odd parity when the parity slot is compiled in.
        cycle(1'b1, 8'h07);
        drain();

        // Back-to-back: second word taken in the STOP slot, busy never drops between frames.
        busy_seen = 0;
        done_seen = 0;
        cycle(1'b1, 8'h3C);
        repeat (FRAME) cycle(1'b1, 8'hFF);
        repeat (FRAME + 1) cycle(1'b0, 8'h00);
        check("b2b busy cycles", busy_seen, 2 * FRAME);
        check("b2b done pulses", done_seen, 2);

        // Load data churns while a frame is in flight; only the STOP slot may take a new word.
        cycle(1'b1, 8'h96);
        repeat (FRAME - 1) cycle(1'b1, $urandom);
        cycle(1'b0, 8'h00);
        drain();

        // 0x80: MSB-first wire 0 then 1,0,0,0,0,0,0,0.
        cycle(1'b1, 8'h80);
        drain();

        // Reset during the 4th data bit aborts the frame immediately without a done pulse.
        cycle(1'b1, 8'h5A);
        repeat (4) cycle(1'b0, 8'h00);
        check_outs();
        #2 reset = 1'b0;
        #1;
        check("lsb async reset", {if_lsb.sel, if_lsb.din, if_lsb.busy, if_lsb.done}, 4'b0000);
        check("msb async reset", {if_msb.sel, if_msb.din, if_msb.busy, if_msb.done}, 4'b0000);
        q_lsb.delete();
        q_msb.delete();
        cur_lsb = '0;
        cur_msb = '0;
        @(posedge clk);
        #1 check("done held low in reset", {if_lsb.done, if_msb.done}, 2'b00);
        @(negedge clk);
        reset = 1'b1;
        cycle(1'b1, 8'h55);
        drain();

        // Random traffic with sparse valids and data that keeps changing.
        repeat (300) cycle($urandom_range(0, 3) == 0, $urandom);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
